fetch_seq: RTL and testbench

Multi-cycle instruction fetch stage for the sequential Y86-64 core. Takes the next PC produced by `pc_update` and reads the instruction one byte per transaction from a byte-wide instruction memory. It assembles the bytes into the decoded fetch fields (icode, ifun, rA, rB, valC, valP) and holds them for the decode stage under a valid/ready handshake.

---
 rtl/y86_pkg.sv | 29 ++
 rtl/fetch_len_decode.sv | 63 ++++++
 rtl/fetch_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and fetch FSM state type.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] R_NONE = 4'hF;

   localparam logic [3:0] OPQ_IFUN_MAX  = 4'd3;
   localparam logic [3:0] CMOV_IFUN_MAX = 4'd6;
   localparam logic [3:0] JXX_IFUN_MAX  = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } fetch_state_e;

endpackage

// File: rtl/fetch_len_decode.sv
// Decodes instruction byte 0 into length, field layout and legality.
module fetch_len_decode
   import y86_pkg::*;
(
   input  logic [7:0] byte0_i,
   output logic [3:0] len_o,
   output logic       has_regs_o,
   output logic       has_valc_o,
   output logic [3:0] valc_off_o,
   output logic       legal_o
);

   logic [3:0] icode;
   logic [3:0] ifun;

   assign icode = byte0_i[7:4];
   assign ifun  = byte0_i[3:0];

   always_comb begin
      len_o      = 4'd1;
      has_regs_o = 1'b0;
      has_valc_o = 1'b0;
      valc_off_o = 4'd0;
      legal_o    = (ifun == 4'd0);
      case (icode)
         I_HALT, I_NOP, I_RET: begin
         end
         I_CMOVXX: begin
            len_o      = 4'd2;
            has_regs_o = 1'b1;
            legal_o    = (ifun <= CMOV_IFUN_MAX);
         end
         I_OPQ: begin
            len_o      = 4'd2;
            has_regs_o = 1'b1;
            legal_o    = (ifun <= OPQ_IFUN_MAX);
         end
         I_PUSHQ, I_POPQ: begin
            len_o      = 4'd2;
            has_regs_o = 1'b1;
         end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            len_o      = 4'd10;
            has_regs_o = 1'b1;
            has_valc_o = 1'b1;
            valc_off_o = 4'd2;
         end
         I_JXX: begin
            len_o      = 4'd9;
            has_valc_o = 1'b1;
            valc_off_o = 4'd1;
            legal_o    = (ifun <= JXX_IFUN_MAX);
         end
         I_CALL: begin
            len_o      = 4'd9;
            has_valc_o = 1'b1;
            valc_off_o = 4'd1;
         end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_seq.sv
// Byte-serial Y86-64 fetch stage with a valid/ready output handshake.
// Optional FETCH_ADDR_LIMIT_EN: refuse requests at or beyond MEM_SIZE.
module fetch_seq
   import y86_pkg::*;
#(
   parameter logic [63:0] MEM_SIZE = 64'd4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_rdata,
   input  logic        imem_err,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic        instr_valid,
   output logic        imem_error,
   output logic        out_valid,
   input  logic        out_ready
);

   fetch_state_e state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic [3:0]   idx_q, idx_d;
   logic         req_q, req_d;
   logic [63:0]  addr_q, addr_d;
   logic [3:0]   icode_q, icode_d, ifun_q, ifun_d;
   logic [3:0]   ra_q, ra_d, rb_q, rb_d;
   logic [63:0]  valc_q, valc_d, valp_q, valp_d;
   logic         ivalid_q, ivalid_d, err_q, err_d;

   logic [7:0]   dec_in;
   logic [3:0]   dec_len, dec_voff;
   logic         dec_has_regs, dec_has_valc, dec_legal;
   logic [2:0]   vidx;
   logic [63:0]  next_addr;
   logic         addr_blocked;

   // Byte 0 is decoded straight off the bus; later bytes reuse the latched opcode.
   assign dec_in = (idx_q == 4'd0) ? imem_rdata : {icode_q, ifun_q};

   fetch_len_decode u_len_decode (
      .byte0_i    (dec_in),
      .len_o      (dec_len),
      .has_regs_o (dec_has_regs),
      .has_valc_o (dec_has_valc),
      .valc_off_o (dec_voff),
      .legal_o    (dec_legal)
   );

   assign vidx      = 3'(idx_q - dec_voff);
   assign next_addr = req_q ? (addr_q + 64'd1) : pc_q;

`ifdef FETCH_ADDR_LIMIT_EN
   assign addr_blocked = (next_addr >= MEM_SIZE);
`else
   logic unused_mem_size;
   assign addr_blocked    = 1'b0;
   assign unused_mem_size = ^MEM_SIZE;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      idx_d    = idx_q;
      req_d    = req_q;
      addr_d   = addr_q;
      icode_d  = icode_q;
      ifun_d   = ifun_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      valc_d   = valc_q;
      valp_d   = valp_q;
      ivalid_d = ivalid_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (pc_valid) begin
               state_d  = S_REQ;
               pc_d     = pc_in;
               idx_d    = 4'd0;
               icode_d  = 4'd0;
               ifun_d   = 4'd0;
               ra_d     = R_NONE;
               rb_d     = R_NONE;
               valc_d   = 64'd0;
               valp_d   = pc_in + 64'd1;
               ivalid_d = 1'b0;
               err_d    = 1'b0;
            end
         end
         S_REQ: begin
            if (!req_q) begin
               if (addr_blocked) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  req_d  = 1'b1;
                  addr_d = next_addr;
               end
            end else if (imem_ack) begin
               if (imem_err) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  req_d   = 1'b0;
               end else begin
                  idx_d = idx_q + 4'd1;
                  if (idx_q == 4'd0) begin
                     icode_d  = imem_rdata[7:4];
                     ifun_d   = imem_rdata[3:0];
                     ivalid_d = dec_legal;
                     valp_d   = pc_q + {60'd0, dec_len};
                     // Register byte not yet seen reads as zero if the fetch aborts.
                     if (dec_has_regs) begin
                        ra_d = 4'd0;
                        rb_d = 4'd0;
                     end
                  end
                  if (dec_has_regs && idx_q == 4'd1) begin
                     ra_d = imem_rdata[7:4];
                     rb_d = imem_rdata[3:0];
                  end
                  if (dec_has_valc && idx_q >= dec_voff) begin
                     valc_d[{vidx, 3'b000} +: 8] = imem_rdata;
                  end
                  if (idx_q + 4'd1 == dec_len) begin
                     state_d = S_DONE;
                     req_d   = 1'b0;
                  end else if (addr_blocked) begin
                     state_d = S_DONE;
                     err_d   = 1'b1;
                     req_d   = 1'b0;
                  end else begin
                     addr_d = next_addr;
                  end
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= 64'd0;
         idx_q    <= 4'd0;
         req_q    <= 1'b0;
         addr_q   <= 64'd0;
         icode_q  <= 4'd0;
         ifun_q   <= 4'd0;
         ra_q     <= R_NONE;
         rb_q     <= R_NONE;
         valc_q   <= 64'd0;
         valp_q   <= 64'd0;
         ivalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         idx_q    <= idx_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         icode_q  <= icode_d;
         ifun_q   <= ifun_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         valc_q   <= valc_d;
         valp_q   <= valp_d;
         ivalid_q <= ivalid_d;
         err_q    <= err_d;
      end
   end

   assign pc_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign icode       = icode_q;
   assign ifun        = ifun_q;
   assign rA          = ra_q;
   assign rB          = rb_q;
   assign valC        = valc_q;
   assign valP        = valp_q;
   assign instr_valid = ivalid_q;
   assign imem_error  = err_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: vector table, scoreboard queue, corner sequences.
module tb_fetch_seq;

   localparam logic [63:0] NOERR = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [7:0]  imem_rdata;
   logic        imem_err;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic        instr_valid, imem_error, out_valid, out_ready;

   fetch_seq dut (
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .pc_valid    (pc_valid),
      .pc_ready    (pc_ready),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .imem_err    (imem_err),
      .icode       (icode),
      .ifun        (ifun),
      .rA          (rA),
      .rB          (rB),
      .valC        (valC),
      .valP        (valP),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   // Byte memory model: image placed at base, optional fault offset, fixed wait states.
   logic [7:0]  prog [16];
   logic [63:0] base = 64'd0;
   logic [63:0] err_off = NOERR;
   logic [63:0] off;
   int          wait_cfg = 0;
   int          wcnt = 0;
   logic        saw_hi = 1'b0;

   always_comb begin
      off        = imem_addr - base;
      imem_ack   = imem_req && (wcnt == 0);
      imem_rdata = (off < 64'd16) ? prog[off[3:0]] : 8'h00;
      imem_err   = (off == err_off);
   end

   always @(posedge clk) begin
      if (!imem_req || imem_ack) wcnt <= wait_cfg;
      else                       wcnt <= wcnt - 1;
      if (imem_req && imem_addr == 64'h1000) saw_hi <= 1'b1;
   end

   typedef struct {
      logic [63:0] pc;
      logic [79:0] mem;
      logic [63:0] erri;
      int          wt;
      logic [3:0]  ic, fn, ra, rb;
      logic [63:0] vc, vp;
      logic        iv, chk_iv, er;
      int          lat, nb;
   } vec_t;

   vec_t tbl [12];
   vec_t sb [$];
   vec_t lv;
   int   errors = 0;
   int   checks = 0;
   int   hlat, hnb, nv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic start(input logic [63:0] pc, input logic [79:0] mem,
                        input logic [63:0] erri, input int wt);
      for (int k = 0; k < 10; k++) prog[k] = mem[8*(9-k) +: 8];
      for (int k = 10; k < 16; k++) prog[k] = 8'h00;
      base     = pc;
      err_off  = erri;
      wait_cfg = wt;
      @(negedge clk);
      pc_in    = pc;
      pc_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pc_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int nb);
      lat = 0;
      nb  = 0;
      while (!out_valid && lat < 200) begin
         if (imem_req && imem_ack && !imem_err) nb++;
         @(negedge clk);
         lat++;
      end
      chk("timeout_out_valid", 64'(out_valid), 64'd1);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int   lat, nb;
      vec_t e;
      out_ready = 1'b1;
      start(v.pc, v.mem, v.erri, v.wt);
      sb.push_back(v);
      wait_done(lat, nb);
      e = sb.pop_front();
      chk({tag, ".icode"}, 64'(icode), 64'(e.ic));
      chk({tag, ".ifun"},  64'(ifun),  64'(e.fn));
      chk({tag, ".rA"},    64'(rA),    64'(e.ra));
      chk({tag, ".rB"},    64'(rB),    64'(e.rb));
      chk({tag, ".valC"},  valC,       e.vc);
      chk({tag, ".valP"},  valP,       e.vp);
      if (e.chk_iv) chk({tag, ".instr_valid"}, 64'(instr_valid), 64'(e.iv));
      chk({tag, ".imem_error"}, 64'(imem_error), 64'(e.er));
      chk({tag, ".latency"},    64'(lat),        64'(e.lat));
      chk({tag, ".bytes"},      64'(nb),         64'(e.nb));
      chk({tag, ".req_idle"},   64'(imem_req),   64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      pc_valid  = 1'b0;
      pc_in     = 64'd0;
      out_ready = 1'b0;
      for (int k = 0; k < 16; k++) prog[k] = 8'h00;

      tbl[0]  = '{64'h100, 80'h30F30807060504030201, NOERR, 0, 4'h3, 4'h0, 4'hF, 4'h3,
                  64'h0102030405060708, 64'h10A, 1'b1, 1'b1, 1'b0, 11, 10};
      tbl[1]  = '{64'h20, {8'h90, 72'h0}, NOERR, 0, 4'h9, 4'h0, 4'hF, 4'hF,
                  64'h0, 64'h21, 1'b1, 1'b1, 1'b0, 2, 1};
      tbl[2]  = '{64'h0, {8'hF0, 72'h0}, NOERR, 0, 4'hF, 4'h0, 4'hF, 4'hF,
                  64'h0, 64'h1, 1'b0, 1'b1, 1'b0, 2, 1};
      tbl[3]  = '{64'h0, {16'h6512, 64'h0}, NOERR, 0, 4'h6, 4'h5, 4'h1, 4'h2,
                  64'h0, 64'h2, 1'b0, 1'b1, 1'b0, 3, 2};
      tbl[4]  = '{64'h40, 80'h70112233445566778899, 64'd3, 0, 4'h7, 4'h0, 4'hF, 4'hF,
                  64'h2211, 64'h49, 1'b1, 1'b1, 1'b1, 5, 3};
      tbl[5]  = '{NOERR, {8'h10, 72'h0}, NOERR, 0, 4'h1, 4'h0, 4'hF, 4'hF,
                  64'h0, 64'h0, 1'b1, 1'b1, 1'b0, 2, 1};
      tbl[6]  = '{64'h200, 80'h80EFCDAB896745230100, NOERR, 1, 4'h8, 4'h0, 4'hF, 4'hF,
                  64'h0123456789ABCDEF, 64'h209, 1'b1, 1'b1, 1'b0, 19, 9};
      tbl[7]  = '{64'h300, {16'h4057, 64'h0}, 64'd2, 0, 4'h4, 4'h0, 4'h5, 4'h7,
                  64'h0, 64'h30A, 1'b1, 1'b1, 1'b1, 4, 2};
      tbl[8]  = '{64'h500, {8'h21, 72'h0}, 64'd0, 0, 4'h0, 4'h0, 4'hF, 4'hF,
                  64'h0, 64'h501, 1'b0, 1'b0, 1'b1, 2, 0};
      tbl[9]  = '{64'h600, {16'h2712, 64'h0}, NOERR, 0, 4'h2, 4'h7, 4'h1, 4'h2,
                  64'h0, 64'h602, 1'b0, 1'b1, 1'b0, 3, 2};
      tbl[10] = '{64'h700, {16'hA08F, 64'h0}, NOERR, 0, 4'hA, 4'h0, 4'h8, 4'hF,
                  64'h0, 64'h702, 1'b1, 1'b1, 1'b0, 3, 2};
      tbl[11] = '{64'h800, 80'h50121122334455667788, NOERR, 2, 4'h5, 4'h0, 4'h1, 4'h2,
                  64'h8877665544332211, 64'h80A, 1'b1, 1'b1, 1'b0, 31, 10};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.pc_ready",    64'(pc_ready),    64'd1);
      chk("rst.imem_req",    64'(imem_req),    64'd0);
      chk("rst.imem_addr",   imem_addr,        64'd0);
      chk("rst.out_valid",   64'(out_valid),   64'd0);
      chk("rst.instr_valid", 64'(instr_valid), 64'd0);
      chk("rst.imem_error",  64'(imem_error),  64'd0);
      chk("rst.icode",       64'(icode),       64'd0);
      chk("rst.ifun",        64'(ifun),        64'd0);
      chk("rst.rA",          64'(rA),          64'hF);
      chk("rst.rB",          64'(rB),          64'hF);
      chk("rst.valC",        valC,             64'd0);
      chk("rst.valP",        valP,             64'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), tbl[i]);

      // Output hold under back-pressure; pc_valid during DONE must be ignored.
      out_ready = 1'b0;
      start(64'h20, {8'h90, 72'h0}, NOERR, 0);
      wait_done(hlat, hnb);
      chk("hold.latency", 64'(hlat), 64'd2);
      nv = 0;
      while (out_valid && nv < 20) begin
         nv++;
         chk("hold.icode",    64'(icode),    64'h9);
         chk("hold.valP",     valP,          64'h21);
         chk("hold.pc_ready", 64'(pc_ready), 64'd0);
         pc_in     = 64'h999;
         pc_valid  = (nv < 6);
         out_ready = (nv == 6);
         @(negedge clk);
      end
      pc_valid  = 1'b0;
      out_ready = 1'b0;
      chk("hold.cycles",      64'(nv),       64'd6);
      chk("hold.pc_ready_end", 64'(pc_ready), 64'd1);
      @(negedge clk);
      chk("hold.no_req",      64'(imem_req), 64'd0);

      // Reset in the middle of an irmovq fetch.
      out_ready = 1'b1;
      start(64'h100, 80'h30F30807060504030201, NOERR, 0);
      repeat (3) @(negedge clk);
      chk("rstmid.req_before", 64'(imem_req), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstmid.imem_req",    64'(imem_req),    64'd0);
      chk("rstmid.imem_addr",   imem_addr,        64'd0);
      chk("rstmid.pc_ready",    64'(pc_ready),    64'd1);
      chk("rstmid.out_valid",   64'(out_valid),   64'd0);
      chk("rstmid.instr_valid", 64'(instr_valid), 64'd0);
      chk("rstmid.icode",       64'(icode),       64'd0);
      chk("rstmid.rA",          64'(rA),          64'hF);
      chk("rstmid.rB",          64'(rB),          64'hF);
      chk("rstmid.valC",        valC,             64'd0);
      chk("rstmid.valP",        valP,             64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_vec("after_rst", tbl[0]);

`ifdef FETCH_ADDR_LIMIT_EN
      lv = '{64'hFFC, {32'h73010203, 48'h0}, NOERR, 0, 4'h7, 4'h3, 4'hF, 4'hF,
             64'h030201, 64'h1005, 1'b1, 1'b1, 1'b1, 5, 4};
      run_vec("limit", lv);
      chk("limit.no_req_1000", 64'(saw_hi), 64'd0);
`else
      lv = '{64'hFFC, 80'h73010203040506070800, NOERR, 0, 4'h7, 4'h3, 4'hF, 4'hF,
             64'h0807060504030201, 64'h1005, 1'b1, 1'b1, 1'b0, 10, 9};
      run_vec("nolimit", lv);
      chk("nolimit.req_1000", 64'(saw_hi), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
